adc_captura_multicanal: RTL
===========================

ADC_CAPTURA_MULTICANAL -- requirements
Module: adc_captura_multicanal

Interface
REQ-001 Parameter NCH, 2, number of ADC channels sharing CS and sclk, one serial data line each.
REQ-002 Parameter DATA_W, 12, useful bits per sample.
REQ-003 Parameter LEAD_ZEROS, 4, leading garbage bits per frame; FRAME_BITS = LEAD_ZEROS + DATA_W.
REQ-004 Parameter SCLK_DIV, 50, system cycles per sclk half-period (>= 1).
REQ-005 Parameter SAMPLE_DIV, 2268, system cycles between continuous-mode conversions (>= 2*SCLK_DIV*(FRAME_BITS+1) + CS_QUIET + 2).
REQ-006 Parameter CS_QUIET, 4, minimum system cycles CS stays high between frames.
REQ-007 clk100MHz  in  1  system clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 inicio  in  1  mode 0: start pulse; mode 1: continuous-run enable level.
REQ-010 modo  in  1  0 = single-shot, 1 = continuous.
REQ-011 leido  in  1  consumer acknowledge; clears listo and overrun.
REQ-012 datoADC  in  NCH  serial data, bit i from channel i, MSB first.
REQ-013 sclk  out  1  ADC serial clock, idles high.
REQ-014 CS  out  1  ADC chip select, active-low.
REQ-015 dato  out  NCH*DATA_W  captured samples, channel i at bits [i*DATA_W +: DATA_W].
REQ-016 listo  out  1  data valid level, held until leido.
REQ-017 ocupado  out  1  high while a frame is in progress (CS low).
REQ-018 overrun  out  1  sticky: a frame completed while listo was still high.
REQ-019 error_trama  out  1  any channel returned a 1 in a leading-zero bit of the last frame.

Function
REQ-020 FSM states IDLE, SETUP, SHIFT, DONE, QUIET shall be implemented; registered outputs only.
REQ-021 IDLE -> SETUP shall occur when (modo=0 and inicio=1) or (modo=1, inicio=1, sample tick); CS falls on that edge.
REQ-022 SETUP shall hold CS low, sclk high for SCLK_DIV cycles, then enter SHIFT.
REQ-023 SHIFT shall toggle sclk every SCLK_DIV cycles, starting with a falling edge, for FRAME_BITS full periods.
REQ-024 datoADC shall be sampled on the system cycle in which sclk goes 0->1, shifted MSB first per channel.
REQ-025 First LEAD_ZEROS bits shall be discarded from data; any 1 among them sets the frame's error flag.
REQ-026 On the FRAME_BITS-th rising sclk edge, DONE shall follow: CS high, sclk high, dato and error_trama loaded, listo=1, all in the same cycle.
REQ-027 listo shall assert exactly 2*SCLK_DIV*FRAME_BITS + SCLK_DIV + 1 cycles after CS falls (defaults: 1651).
REQ-028 QUIET shall hold CS high CS_QUIET cycles, then return to IDLE.
REQ-029 ocupado = 1 from the CS fall edge until CS rise edge inclusive of SETUP/SHIFT only.
REQ-030 Sample tick counter shall run free (period SAMPLE_DIV) only while modo=1 and inicio=1; cleared otherwise.
REQ-031 inicio, ticks and modo changes during SETUP/SHIFT/DONE/QUIET shall be ignored; modo sampled only in IDLE.
REQ-032 leido shall clear listo and overrun next edge; dato and error_trama hold.
REQ-033 Frame completion with listo=1 and leido=0 shall set overrun and overwrite dato.
REQ-034 Frame completion coincident with leido=1 shall leave listo=1 and overrun unchanged (new data, old acknowledged).
REQ-035 Continuous mode with inicio deasserted mid-frame shall finish that frame normally, then stop.

Reset
REQ-036 reset=0 shall immediately force: state IDLE, CS=1, sclk=1, ocupado=0, listo=0, overrun=0, error_trama=0, dato=0, all counters/shift registers 0.
REQ-037 reset mid-frame shall abort with no listo; the first frame after release shall be complete and correct.

Verification (NCH=2, DATA_W=12, LEAD_ZEROS=4, SCLK_DIV=2, CS_QUIET=4, SAMPLE_DIV=200)
REQ-038 Single-shot: ch0 0000_1010_0101_0011, ch1 0000_1111_0000_0001 -> dato=24'hF01A53, error_trama=0, listo 67 cycles after CS fall, exactly 16 sclk rising edges.
REQ-039 Garbage bit: ch0 leading 1000, data 0xFFF -> dato[11:0]=12'hFFF, error_trama=1.
REQ-040 Continuous, no leido: two frames 0x123 then 0x456 on ch0 -> after second, overrun=1, dato[11:0]=12'h456; one leido pulse -> listo=0, overrun=0.
REQ-041 Reset low after 10th sclk rising edge -> CS=1, sclk=1, listo=0, dato=0 same cycle; next inicio yields correct frame.
REQ-042 Extra inicio pulses during SHIFT -> exactly one listo; leido on completion cycle -> listo stays 1, overrun=0.

Source files
------------

// File: rtl/adc_captura_multicanal.sv
// Multi-channel serial ADC capture. Every channel shares one CS and one sclk
// and has its own data line. A frame is LEAD_ZEROS garbage bits followed by
// DATA_W data bits, MSB first. Frames start on a pulse (single-shot) or on a
// periodic tick (continuous). The captured words are held until the consumer
// acknowledges them.
module adc_captura_multicanal #(
    parameter int NCH        = 2,
    parameter int DATA_W     = 12,
    parameter int LEAD_ZEROS = 4,
    parameter int SCLK_DIV   = 50,
    parameter int SAMPLE_DIV = 2268,
    parameter int CS_QUIET   = 4
) (
    input  logic                  clk100MHz,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic                  modo,
    input  logic                  leido,
    input  logic [NCH-1:0]        datoADC,
    output logic                  sclk,
    output logic                  CS,
    output logic [NCH*DATA_W-1:0] dato,
    output logic                  listo,
    output logic                  ocupado,
    output logic                  overrun,
    output logic                  error_trama
);

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
    localparam int CNT_W      = $clog2(SCLK_DIV + CS_QUIET + 1);
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int TICK_W     = $clog2(SAMPLE_DIV + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

    state_t                             state;
    state_t                             state_next;
    logic [CNT_W-1:0]                   cnt;
    logic [BIT_W-1:0]                   bit_cnt;
    logic [TICK_W-1:0]                  tick_cnt;
    logic [NCH-1:0][FRAME_BITS-1:0]     shreg;
    logic                               run;
    logic                               tick;
    logic                               div_end;
    logic                               quiet_end;
    logic                               frame_end;
    logic                               toggle;
    logic                               rise;
    logic                               load;
    logic                               busy_next;
    logic [NCH*DATA_W-1:0]              new_dato;
    logic                               new_err;

    assign run       = modo && inicio;
    assign tick      = run && (tick_cnt == '0);
    assign div_end   = (cnt == CNT_W'(SCLK_DIV - 1));
    assign quiet_end = (cnt == CNT_W'(CS_QUIET - 1));
    assign frame_end = (bit_cnt == BIT_W'(FRAME_BITS));
    assign toggle    = (state == SHIFT) && !frame_end && div_end;
    assign rise      = toggle && !sclk;
    assign load      = (state == SHIFT) && frame_end;
    assign busy_next = (state_next == SETUP) || (state_next == SHIFT);

    // Next-state decode; start requests are only looked at while idle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (inicio && (!modo || tick)) state_next = SETUP;
            SETUP:   if (div_end) state_next = SHIFT;
            SHIFT:   if (frame_end) state_next = DONE;
            DONE:    state_next = QUIET;
            QUIET:   if (quiet_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Assemble the output word and garbage-bit flag from the shift registers
    always_comb begin
        new_dato = '0;
        new_err  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            new_dato[i*DATA_W +: DATA_W] = shreg[i][DATA_W-1:0];
            new_err = new_err | (|shreg[i][FRAME_BITS-1:DATA_W]);
        end
    end

    // State register
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Phase counter: sclk half-periods in SETUP/SHIFT, CS gap in QUIET
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset)                                   cnt <= '0;
        else if (state != state_next)                 cnt <= '0;
        else if (state == SETUP || state == SHIFT)    cnt <= div_end ? '0 : cnt + CNT_W'(1);
        else if (state == QUIET)                      cnt <= cnt + CNT_W'(1);
        else                                          cnt <= '0;
    end

    // Free-running conversion tick, only alive while continuous mode is enabled
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset)                                        tick_cnt <= '0;
        else if (!run)                                     tick_cnt <= '0;
        else if (tick_cnt == TICK_W'(SAMPLE_DIV - 1))      tick_cnt <= '0;
        else                                               tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // Serial clock: toggles inside SHIFT, parked high everywhere else
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset)               sclk <= 1'b1;
        else if (toggle)          sclk <= ~sclk;
        else if (state != SHIFT)  sclk <= 1'b1;
    end

    // Bit counter and per-channel shift registers, advanced on sclk rising
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (rise) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            for (int i = 0; i < NCH; i++) begin
                shreg[i] <= {shreg[i][FRAME_BITS-2:0], datoADC[i]};
            end
        end
    end

    // Chip select and busy flag follow the upcoming state
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            CS      <= 1'b1;
            ocupado <= 1'b0;
        end else begin
            CS      <= !busy_next;
            ocupado <= busy_next;
        end
    end

    // Result registers and handshake flags
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            dato        <= '0;
            error_trama <= 1'b0;
            listo       <= 1'b0;
            overrun     <= 1'b0;
        end else if (load) begin
            dato        <= new_dato;
            error_trama <= new_err;
            listo       <= 1'b1;
            if (listo && !leido) overrun <= 1'b1;
        end else if (leido) begin
            listo       <= 1'b0;
            overrun     <= 1'b0;
        end
    end

endmodule
